dram_req_scheduler: RTL and testbench

- Sequences requests from one bank's two input-queue heads (mem data queue, mem instr queue) into a single dram_bank port.
- Replaces the combinational pick with a registered, stall-aware issue stage: one request in flight at the bank interface.
- Enforces write-before-read ordering on same-line conflicts and bounds instr-queue starvation.
- One instance per bank side (even/odd).

---
 rtl/dram_req_scheduler.sv | 144 ++++++++++++++
 tb/tb_dram_req_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_req_scheduler.sv
// dram_req_scheduler
// Registered, stall-aware issue stage for one DRAM bank. It chooses between
// the heads of the data queue and the instruction queue and holds a single
// request in flight at the bank interface.
//
// Optional build macro: DRAM_SCHED_AGING_EN
//   defined   -> a saturating starvation counter lets the instruction queue
//                win after STARVE_LIMIT consecutive data-queue grants taken
//                while it was waiting
//   undefined -> the data queue always has priority over the instruction queue
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   dq_*                      data-queue head (valid, addr, data, operation,
//                             src, dest, is_flush); dq_dealloc pops it
//   iq_*                      instr-queue head (same fields, no data);
//                             iq_dealloc pops it
//   bank_stall                bank cannot accept the presented request
//   valid_out .. is_flush_out request register presented to the bank
//   grant_out                 {dq,iq} one-hot owner of the request register,
//                             00 when the register is empty
module dram_req_scheduler #(
    parameter int CL_SIZE      = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dq_valid,
    input  logic [31:0]        dq_addr,
    input  logic [CL_SIZE-1:0] dq_data,
    input  logic [2:0]         dq_operation,
    input  logic [1:0]         dq_src,
    input  logic [1:0]         dq_dest,
    input  logic               dq_is_flush,
    output logic               dq_dealloc,
    input  logic               iq_valid,
    input  logic [31:0]        iq_addr,
    input  logic [2:0]         iq_operation,
    input  logic [1:0]         iq_src,
    input  logic [1:0]         iq_dest,
    input  logic               iq_is_flush,
    output logic               iq_dealloc,
    input  logic               bank_stall,
    output logic               valid_out,
    output logic [31:0]        addr_out,
    output logic [CL_SIZE-1:0] data_out,
    output logic [2:0]         operation_out,
    output logic [1:0]         src_out,
    output logic [1:0]         dest_out,
    output logic               is_flush_out,
    output logic [1:0]         grant_out
);

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t state;
    logic   accept;
    logic   load;
    logic   pick_iq;

    // The register frees up when the bank takes the request; a new head may
    // be loaded in the same cycle so back-to-back requests have no bubble.
    // Loads are blocked while reset is held so no head is popped and lost.
    assign accept = (state == HOLD) & ~bank_stall;
    assign load   = ~rst & ((state == EMPTY) | accept) & (dq_valid | iq_valid);

`ifdef DRAM_SCHED_AGING_EN
    localparam int OFF_W = $clog2(CL_SIZE / 8);
    localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;
    logic             same_line;

    // A read must never overtake a pending write to the same line, so a
    // same-line conflict always hands the grant to the data queue.
    assign same_line = dq_valid & iq_valid & (dq_addr[31:OFF_W] == iq_addr[31:OFF_W]);
    assign starved   = (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign pick_iq   = iq_valid & (~dq_valid | (starved & ~same_line));

    // Count data-queue grants taken while the instruction queue waits.
    // Saturates at the limit so a same-line override keeps the instruction
    // queue first in line for the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (~iq_valid || iq_dealloc) begin
            starve_cnt <= '0;
        end else if (dq_dealloc && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign pick_iq = iq_valid & ~dq_valid;
`endif

    // Exactly one queue is popped per load, in the cycle the load happens.
    assign dq_dealloc = load & ~pick_iq;
    assign iq_dealloc = load &  pick_iq;

    // Issue FSM with registered outputs. A stalled HOLD falls through every
    // branch, so the request register stays frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= EMPTY;
            valid_out     <= 1'b0;
            addr_out      <= '0;
            data_out      <= '0;
            operation_out <= '0;
            src_out       <= '0;
            dest_out      <= '0;
            is_flush_out  <= 1'b0;
            grant_out     <= 2'b00;
        end else if (load) begin
            state     <= HOLD;
            valid_out <= 1'b1;
            if (pick_iq) begin
                addr_out      <= iq_addr;
                data_out      <= '0;
                operation_out <= iq_operation;
                src_out       <= iq_src;
                dest_out      <= iq_dest;
                is_flush_out  <= iq_is_flush;
                grant_out     <= 2'b01;
            end else begin
                addr_out      <= dq_addr;
                data_out      <= dq_data;
                operation_out <= dq_operation;
                src_out       <= dq_src;
                dest_out      <= dq_dest;
                is_flush_out  <= dq_is_flush;
                grant_out     <= 2'b10;
            end
        end else if (accept) begin
            state     <= EMPTY;
            valid_out <= 1'b0;
            grant_out <= 2'b00;
        end
    end

endmodule

// File: tb/tb_dram_req_scheduler.sv
// Testbench for dram_req_scheduler: directed vectors feed model queues whose
// heads drive the DUT. Expected bank requests are pushed in hand-computed
// order, and a negedge monitor compares every presented request with the front
// of the expected queue.
module tb_dram_req_scheduler;

    localparam int CL_SIZE = 128;

    typedef struct packed {
        logic [31:0]        addr;
        logic [CL_SIZE-1:0] data;
        logic [2:0]         op;
        logic [1:0]         src;
        logic [1:0]         dest;
        logic               flush;
        logic [1:0]         grant;
    } item_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               dq_valid;
    logic [31:0]        dq_addr;
    logic [CL_SIZE-1:0] dq_data;
    logic [2:0]         dq_operation;
    logic [1:0]         dq_src;
    logic [1:0]         dq_dest;
    logic               dq_is_flush;
    logic               dq_dealloc;
    logic               iq_valid;
    logic [31:0]        iq_addr;
    logic [2:0]         iq_operation;
    logic [1:0]         iq_src;
    logic [1:0]         iq_dest;
    logic               iq_is_flush;
    logic               iq_dealloc;
    logic               bank_stall;
    logic               valid_out;
    logic [31:0]        addr_out;
    logic [CL_SIZE-1:0] data_out;
    logic [2:0]         operation_out;
    logic [1:0]         src_out;
    logic [1:0]         dest_out;
    logic               is_flush_out;
    logic [1:0]         grant_out;

    item_t dq_q[$];
    item_t iq_q[$];
    item_t exp_q[$];

    int checks      = 0;
    int failures    = 0;
    int cycle       = 0;
    int last_accept = 0;

    // Hand-computed grant orders for the sustained-contention test:
    // values below 100 are data-queue items, 100+ are instr-queue items.
    int ord_aging[13]  = '{0, 1, 2, 3, 100, 4, 5, 6, 7, 101, 8, 9, 102};
    int ord_strict[13] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 100, 101, 102};

    dram_req_scheduler #(.CL_SIZE(CL_SIZE), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .dq_valid(dq_valid), .dq_addr(dq_addr), .dq_data(dq_data),
        .dq_operation(dq_operation), .dq_src(dq_src), .dq_dest(dq_dest),
        .dq_is_flush(dq_is_flush), .dq_dealloc(dq_dealloc),
        .iq_valid(iq_valid), .iq_addr(iq_addr), .iq_operation(iq_operation),
        .iq_src(iq_src), .iq_dest(iq_dest), .iq_is_flush(iq_is_flush),
        .iq_dealloc(iq_dealloc), .bank_stall(bank_stall),
        .valid_out(valid_out), .addr_out(addr_out), .data_out(data_out),
        .operation_out(operation_out), .src_out(src_out), .dest_out(dest_out),
        .is_flush_out(is_flush_out), .grant_out(grant_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Every field of a request is derived from its address so expectations
    // can be written down from the address alone.
    function automatic item_t mk(input logic [31:0] a, input logic [1:0] g);
        item_t it;
        it.addr  = a;
        it.data  = {4{a ^ 32'h5A5A_0000}};
        it.op    = a[7:5] ^ 3'd3;
        it.src   = a[9:8];
        it.dest  = a[11:10];
        it.flush = a[6];
        it.grant = g;
        return it;
    endfunction

    task automatic checkOutput(input string name, input logic [CL_SIZE-1:0] act,
                               input logic [CL_SIZE-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic driveHeads();
        dq_valid     = (dq_q.size() != 0);
        dq_addr      = dq_valid ? dq_q[0].addr  : '0;
        dq_data      = dq_valid ? dq_q[0].data  : '0;
        dq_operation = dq_valid ? dq_q[0].op    : '0;
        dq_src       = dq_valid ? dq_q[0].src   : '0;
        dq_dest      = dq_valid ? dq_q[0].dest  : '0;
        dq_is_flush  = dq_valid ? dq_q[0].flush : 1'b0;
        iq_valid     = (iq_q.size() != 0);
        iq_addr      = iq_valid ? iq_q[0].addr  : '0;
        iq_operation = iq_valid ? iq_q[0].op    : '0;
        iq_src       = iq_valid ? iq_q[0].src   : '0;
        iq_dest      = iq_valid ? iq_q[0].dest  : '0;
        iq_is_flush  = iq_valid ? iq_q[0].flush : 1'b0;
    endtask

    task automatic applyStimulus(input bit is_iq, input logic [31:0] a);
        if (is_iq) iq_q.push_back(mk(a, 2'b01));
        else       dq_q.push_back(mk(a, 2'b10));
        driveHeads();
    endtask

    task automatic expectOut(input bit is_iq, input logic [31:0] a);
        item_t e;
        e = mk(a, is_iq ? 2'b01 : 2'b10);
        if (is_iq) e.data = '0;
        exp_q.push_back(e);
    endtask

    task automatic waitDrain(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checkOutput("drain_timeout", 128'(exp_q.size()), '0);
            exp_q.delete();
        end
    endtask

    // Upstream queue model: pop a head on the edge where its dealloc was seen.
    initial begin
        logic dq_take;
        logic iq_take;
        forever begin
            @(negedge clk);
            dq_take = dq_dealloc;
            iq_take = iq_dealloc;
            @(posedge clk);
            #1;
            if (dq_take && dq_q.size() != 0) void'(dq_q.pop_front());
            if (iq_take && iq_q.size() != 0) void'(iq_q.pop_front());
            driveHeads();
        end
    end

    // Monitor: every presented request must match the expected front; it
    // retires only when the bank accepts it, so stalled cycles re-check it.
    always @(negedge clk) begin
        item_t e;
        if (!rst) begin
            checkOutput("single_dealloc", 128'(dq_dealloc & iq_dealloc), '0);
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_request", 128'(addr_out), '1);
                end else begin
                    e = exp_q[0];
                    checkOutput("addr_out",      128'(addr_out),      128'(e.addr));
                    checkOutput("data_out",      data_out,            e.data);
                    checkOutput("operation_out", 128'(operation_out), 128'(e.op));
                    checkOutput("src_out",       128'(src_out),       128'(e.src));
                    checkOutput("dest_out",      128'(dest_out),      128'(e.dest));
                    checkOutput("is_flush_out",  128'(is_flush_out),  128'(e.flush));
                    checkOutput("grant_out",     128'(grant_out),     128'(e.grant));
                    if (!bank_stall) begin
                        void'(exp_q.pop_front());
                        last_accept = cycle;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int start;
        int idx;
        rst        = 1'b1;
        bank_stall = 1'b0;
        driveHeads();
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_valid_out",  128'(valid_out),  '0);
        checkOutput("rst_grant_out",  128'(grant_out),  '0);
        checkOutput("rst_addr_out",   128'(addr_out),   '0);
        checkOutput("rst_data_out",   data_out,         '0);
        checkOutput("rst_dq_dealloc", 128'(dq_dealloc), '0);
        checkOutput("rst_iq_dealloc", 128'(iq_dealloc), '0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Single data-queue request: pop this cycle, presented next cycle.
        $display("[TB] test 1: single dq request");
        @(posedge clk);
        #2;
        start = cycle;
        applyStimulus(1'b0, 32'h100);
        expectOut(1'b0, 32'h100);
        @(negedge clk);
        checkOutput("t1_dq_dealloc", 128'(dq_dealloc), 128'(1));
        checkOutput("t1_iq_dealloc", 128'(iq_dealloc), '0);
        waitDrain(20);
        checkOutput("t1_latency", 128'(last_accept - start), 128'(1));

        // Both queues, different lines: dq first, iq next with no bubble.
        $display("[TB] test 2: dq over iq, back-to-back");
        @(posedge clk);
        #2;
        start = cycle;
        applyStimulus(1'b0, 32'h200);
        applyStimulus(1'b1, 32'h310);
        expectOut(1'b0, 32'h200);
        expectOut(1'b1, 32'h310);
        waitDrain(20);
        checkOutput("t2_back_to_back", 128'(last_accept - start), 128'(2));

        // Five stalled cycles with new heads waiting: frozen, no pops.
        $display("[TB] test 3: bank stall");
        @(posedge clk);
        #2;
        bank_stall = 1'b1;
        applyStimulus(1'b0, 32'h500);
        applyStimulus(1'b0, 32'h520);
        applyStimulus(1'b1, 32'h640);
        expectOut(1'b0, 32'h500);
        expectOut(1'b0, 32'h520);
        expectOut(1'b1, 32'h640);
        @(posedge clk);
        repeat (5) begin
            @(negedge clk);
            checkOutput("t3_stall_valid",      128'(valid_out),  128'(1));
            checkOutput("t3_stall_dq_dealloc", 128'(dq_dealloc), '0);
            checkOutput("t3_stall_iq_dealloc", 128'(iq_dealloc), '0);
        end
        @(posedge clk);
        #2 bank_stall = 1'b0;
        @(negedge clk);
        checkOutput("t3_reload_dq_dealloc", 128'(dq_dealloc), 128'(1));
        waitDrain(20);

        // Four dq grants bring aging to its limit, then a same-line conflict.
        $display("[TB] test 4: same-line conflict");
        @(posedge clk);
        #2;
        applyStimulus(1'b0, 32'h1000);
        applyStimulus(1'b0, 32'h1020);
        applyStimulus(1'b0, 32'h1040);
        applyStimulus(1'b0, 32'h1060);
        applyStimulus(1'b0, 32'h400);
        applyStimulus(1'b1, 32'h408);
        expectOut(1'b0, 32'h1000);
        expectOut(1'b0, 32'h1020);
        expectOut(1'b0, 32'h1040);
        expectOut(1'b0, 32'h1060);
        expectOut(1'b0, 32'h400);
        expectOut(1'b1, 32'h408);
        waitDrain(30);

        // Sustained contention on distinct lines.
        $display("[TB] test 5: sustained contention");
        @(posedge clk);
        #2;
        start = cycle;
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h2000 + 32'(i * 'h40));
        for (int i = 0; i < 3; i++)  applyStimulus(1'b1, 32'h3000 + 32'(i * 'h40));
        for (int i = 0; i < 13; i++) begin
`ifdef DRAM_SCHED_AGING_EN
            idx = ord_aging[i];
`else
            idx = ord_strict[i];
`endif
            if (idx >= 100) expectOut(1'b1, 32'h3000 + 32'((idx - 100) * 'h40));
            else            expectOut(1'b0, 32'h2000 + 32'(idx * 'h40));
        end
        waitDrain(60);
        checkOutput("t5_no_bubble", 128'(last_accept - start), 128'(13));

        // Reset while a stalled request is held: dropped, no pop of the head.
        $display("[TB] test 6: reset mid-hold");
        @(posedge clk);
        #2;
        bank_stall = 1'b1;
        applyStimulus(1'b0, 32'h700);
        applyStimulus(1'b0, 32'h720);
        expectOut(1'b0, 32'h700);
        @(posedge clk);
        #3;
        rst = 1'b1;
        exp_q.delete();
        #1;
        checkOutput("t6_valid_out",  128'(valid_out),  '0);
        checkOutput("t6_grant_out",  128'(grant_out),  '0);
        checkOutput("t6_dq_dealloc", 128'(dq_dealloc), '0);
        @(negedge clk);
        checkOutput("t6_dq_dealloc_held", 128'(dq_dealloc), '0);
        @(posedge clk);
        #2;
        bank_stall = 1'b0;
        expectOut(1'b0, 32'h720);
        rst = 1'b0;
        waitDrain(20);

        @(posedge clk);
        checkOutput("final_exp_empty", 128'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
